// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, port indices and address legality check for mem_port_arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LDR = 1'b1;
   function automatic logic addr_illegal(input logic [63:0] addr, input logic [64:0] limit);
      return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and RAM strobes of the two-port memory arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic req0, req1, we0, we1, gnt0, gnt1, done0, done1, err, busy, mem_read, mem_write;
   logic [ADDR_W-1:0] addr0, addr1, mem_addr;
   logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input gnt0, gnt1, done0, done1, rdata, err, busy, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport slave (
      input req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, done0, done1, rdata, err, busy, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner select; round-robin when MEM_ARB_RR_EN is defined, else port 0 always wins ties
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
`ifdef MEM_ARB_RR_EN
   input  logic last,
`endif
   output logic win
);
`ifdef MEM_ARB_RR_EN
   // on a tie the port that did not win last time is served
   always_comb win = (req0 & req1) ? ~last : (req0 ? PORT_CORE : PORT_LDR);
`else
   // port 0 wins whenever it requests
   always_comb win = req0 ? PORT_CORE : PORT_LDR;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port single-RAM arbiter, IDLE->ACCESS->DONE per access; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input logic clk,
   input logic rst,
   mem_port_arbiter_if.slave bus
);
   state_t state, state_n;
   logic any_req, win, grant, bad, acc_ok, lat_we, lat_win, err_flag;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
`ifdef MEM_ARB_RR_EN
   logic last;
`endif
   assign any_req = bus.req0 | bus.req1;
   assign bad = addr_illegal(64'(lat_addr), 65'(DEPTH_WORDS) << 2);
   mem_arb_pick u_pick (
      .req0(bus.req0),
      .req1(bus.req1),
`ifdef MEM_ARB_RR_EN
      .last(last),
`endif
      .win(win)
   );
   // next state and all handshake/RAM outputs; RAM strobes only in a legal ACCESS
   always_comb begin
      grant = (state == IDLE) & any_req & ~rst;
      acc_ok = (state == ACCESS) & ~bad;
      state_n = (state == IDLE) ? (any_req ? ACCESS : IDLE) : (state == ACCESS) ? DONE : IDLE;
      bus.gnt0 = grant & (win == PORT_CORE);
      bus.gnt1 = grant & (win == PORT_LDR);
      bus.done0 = (state == DONE) & (lat_win == PORT_CORE);
      bus.done1 = (state == DONE) & (lat_win == PORT_LDR);
      bus.err = (state == DONE) & err_flag;
      bus.busy = state != IDLE;
      bus.mem_read = acc_ok & ~lat_we;
      bus.mem_write = acc_ok & lat_we;
      bus.mem_addr = acc_ok ? lat_addr : '0;
      bus.mem_wdata = acc_ok ? lat_wdata : '0;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   // request latch on grant, read capture and error flag at the end of ACCESS
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_we <= 1'b0;
         lat_win <= PORT_CORE;
         lat_addr <= '0;
         lat_wdata <= '0;
         err_flag <= 1'b0;
         bus.rdata <= '0;
`ifdef MEM_ARB_RR_EN
         last <= PORT_LDR;
`endif
      end else begin
         if (grant) begin
            lat_win <= win;
            lat_we <= win ? bus.we1 : bus.we0;
            lat_addr <= win ? bus.addr1 : bus.addr0;
            lat_wdata <= win ? bus.wdata1 : bus.wdata0;
`ifdef MEM_ARB_RR_EN
            last <= win;
`endif
         end
         if (state == ACCESS) begin
            err_flag <= bad;
            if (bad) bus.rdata <= '0;
            else if (!lat_we) bus.rdata <= bus.mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and randomized accesses against a word-level memory model
module tb_mem_port_arbiter;
   localparam int DEPTH = 1024;
   typedef struct {
      bit p;
      bit we;
      logic [31:0] a;
      logic [31:0] d;
      bit xerr;
      logic [31:0] xrd;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] ram [DEPTH] = '{default: 32'h0};
   logic [31:0] model [int];
   logic [31:0] exp_rd = 32'h0;
   bit last_win = 1'b1;
   vec_t tbl [12];
   always #5 clk = ~clk;
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.mem_rdata = ram[bus.mem_addr[11:2]];
   always @(posedge clk) if (bus.mem_write) ram[bus.mem_addr[11:2]] <= bus.mem_wdata;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_bad(logic [31:0] a);
      return (a % 4 != 0) || (64'(a) >= 64'(DEPTH * 4));
   endfunction

   task automatic model_apply(bit we, logic [31:0] a, logic [31:0] d, output bit e);
      int k;
      e = is_bad(a);
      k = int'(a / 4);
      if (e) exp_rd = 32'h0;
      else if (we) model[k] = d;
      else exp_rd = model.exists(k) ? model[k] : 32'h0;
   endtask

   task automatic drive(bit p, bit r, bit we, logic [31:0] a, logic [31:0] d);
      if (p) begin
         bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end
   endtask

   task automatic do_access(bit p, bit we, logic [31:0] a, logic [31:0] d, bit xerr, logic [31:0] xrd);
      @(posedge clk); #1 drive(p, 1'b1, we, a, d);
      @(negedge clk);
      chk("gnt", {bus.gnt1, bus.gnt0}, p ? 2'b10 : 2'b01);
      chk("strobes_idle", {bus.mem_write, bus.mem_read}, 2'b00);
      @(posedge clk); #1 drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("access_strobes", {bus.mem_write, bus.mem_read}, xerr ? 2'b00 : (we ? 2'b10 : 2'b01));
      chk("done_early", {bus.done1, bus.done0}, 2'b00);
      chk("busy_access", bus.busy, 1'b1);
      if (!xerr) chk("mem_addr", bus.mem_addr, a);
      @(negedge clk);
      chk("done", {bus.done1, bus.done0}, p ? 2'b10 : 2'b01);
      chk("err", bus.err, xerr);
      chk("rdata", bus.rdata, xrd);
      chk("strobes_done", {bus.mem_write, bus.mem_read}, 2'b00);
      last_win = p;
   endtask

   task automatic rand_access(bit p, bit we, logic [31:0] a, logic [31:0] d);
      bit e;
      model_apply(we, a, d, e);
      do_access(p, we, a, d, e, exp_rd);
   endtask

   task automatic pair(bit w0, logic [31:0] a0, logic [31:0] d0, bit w1, logic [31:0] a1, logic [31:0] d1);
      bit first, second, e;
`ifdef MEM_ARB_RR_EN
      first = ~last_win;
`else
      first = 1'b0;
`endif
      second = ~first;
      @(posedge clk); #1 drive(1'b0, 1'b1, w0, a0, d0); drive(1'b1, 1'b1, w1, a1, d1);
      @(negedge clk);
      chk("pair_gnt_first", {bus.gnt1, bus.gnt0}, first ? 2'b10 : 2'b01);
      @(posedge clk); #1 drive(first, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("pair_hold", {bus.gnt1, bus.gnt0}, 2'b00);
      @(negedge clk);
      model_apply(first ? w1 : w0, first ? a1 : a0, first ? d1 : d0, e);
      chk("pair_done_first", {bus.done1, bus.done0}, first ? 2'b10 : 2'b01);
      chk("pair_err_first", bus.err, e);
      chk("pair_rdata_first", bus.rdata, exp_rd);
      @(negedge clk);
      chk("pair_gnt_second", {bus.gnt1, bus.gnt0}, second ? 2'b10 : 2'b01);
      @(posedge clk); #1 drive(second, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      model_apply(second ? w1 : w0, second ? a1 : a0, second ? d1 : d0, e);
      chk("pair_done_second", {bus.done1, bus.done0}, second ? 2'b10 : 2'b01);
      chk("pair_err_second", bus.err, e);
      chk("pair_rdata_second", bus.rdata, exp_rd);
      last_win = second;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_done", {bus.done1, bus.done0, bus.err}, 3'b000);
      chk("rst_strobes", {bus.mem_write, bus.mem_read}, 2'b00);
      exp_rd = 32'h0;
      last_win = 1'b1;
   endtask

   initial begin
      int seen;
      bit e;
      tbl[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 1'b0, 32'h13,       32'h0,        1'b1, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 32'h1000,     32'h0,        1'b1, 32'h0};
      tbl[4]  = '{1'b1, 1'b1, 32'hFFC,      32'h12345678, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 1'b0, 32'hFFC,      32'h0,        1'b0, 32'h12345678};
      tbl[6]  = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
      tbl[8]  = '{1'b0, 1'b1, 32'h11,       32'hAAAA5555, 1'b1, 32'h0};
      tbl[9]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
      tbl[10] = '{1'b1, 1'b1, 32'h0,        32'h0BADF00D, 1'b0, 32'hDEADBEEF};
      tbl[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0BADF00D};
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_outputs", {bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err, bus.mem_read, bus.mem_write}, 7'h0);
      chk("reset_rdata", bus.rdata, 32'h0);
      chk("reset_mem_addr", bus.mem_addr, 32'h0);
      for (int i = 0; i < 12; i++) begin
         model_apply(tbl[i].we, tbl[i].a, tbl[i].d, e);
         do_access(tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].xerr, tbl[i].xrd);
      end
      do_reset();
      pair(1'b0, 32'h10, 32'h0, 1'b0, 32'hFFC, 32'h0);
      pair(1'b0, 32'h0, 32'h0, 1'b0, 32'h10, 32'h0);
      @(posedge clk); #1 drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      @(negedge clk);
      chk("rstacc_gnt", bus.gnt0, 1'b1);
      @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b1;
      @(negedge clk);
      chk("rstacc_write_strobe", bus.mem_write, 1'b1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rstacc_no_done", {bus.done1, bus.done0}, 2'b00);
      chk("rstacc_busy", bus.busy, 1'b0);
      chk("rstacc_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      chk("rstacc_no_done_late", {bus.done1, bus.done0}, 2'b00);
      model[32'h20 / 4] = 32'hCAFEF00D;
      exp_rd = 32'h0;
      last_win = 1'b1;
      rand_access(1'b1, 1'b0, 32'h20, 32'h0);
      do_reset();
      seen = -1;
      @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0); drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.gnt1 && seen < 0) seen = c;
         @(posedge clk); #1;
         if (seen >= 0) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef MEM_ARB_RR_EN
      chk("rr_serves_port1", (seen >= 0) && (seen < 6), 1'b1);
`else
      chk("fixed_starves_port1", seen < 0, 1'b1);
`endif
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      chk("drain_idle", bus.busy, 1'b0);
      do_reset();
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         int sel;
         sel = int'($urandom_range(0, 3));
         a = (sel < 2) ? 32'($urandom_range(0, DEPTH - 1) * 4) : (sel == 2) ? 32'($urandom_range(0, 4 * DEPTH + 7)) : 32'($urandom);
         rand_access(1'($urandom), 1'($urandom), a, $urandom);
      end
      for (int i = 0; i < 8; i++)
         pair(1'($urandom), 32'($urandom_range(0, DEPTH - 1) * 4), $urandom, 1'($urandom), 32'($urandom_range(0, DEPTH - 1) * 4), $urandom);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
